// File: rtl/mem_port_arbiter.sv
// Arbitrates one byte-addressed 16-bit memory port between fetch (I) and data (D) requesters,
// adding a programmable access latency. Optional I starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int LATENCY      = 4,   // legal 1..15
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ready,
    output logic                  i_valid,
    output logic [15:0]           i_rdata,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic                  d_ready,
    output logic                  d_valid,
    output logic [15:0]           d_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data_in,
    output logic                  mem_enable,
    output logic                  mem_wr,
    input  logic [15:0]           mem_data_out,
    output logic                  busy,
    output logic                  align_err,
    output logic [1:0]            o_dbg_state
);

    // Handshake: a requester holds req and its fields stable; ready is a one-cycle,
    // combinational accept in IDLE or RESP. valid is a one-cycle completion pulse in RESP.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_cnt;
    logic                  r_port_d;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_wdata;
    logic [15:0]           r_i_rdata;
    logic [15:0]           r_d_rdata;

    logic w_can_grant;
    logic w_grant_i;
    logic w_grant_d;
    logic w_grant;
    logic w_access;
    logic w_resp;
    logic w_starve_hit;

    assign w_can_grant = !rst && (r_state == S_IDLE || r_state == S_RESP);
    assign w_access    = !rst && (r_state == S_ACCESS) && (r_cnt == 4'd0);
    assign w_resp      = !rst && (r_state == S_RESP);

    // D wins contention unless the starvation guard has tripped.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (w_can_grant) begin
            if (d_req && !(i_req && w_starve_hit)) begin
                w_grant_d = 1'b1;
            end else if (i_req) begin
                w_grant_i = 1'b1;
            end
        end
    end

    assign w_grant = w_grant_i | w_grant_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] r_starve;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= 4'd0;
        end else if (w_grant_i || (w_grant && !i_req)) begin
            r_starve <= 4'd0;
        end else if (w_grant_d && i_req) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    assign w_starve_hit = (r_starve == 4'(STARVE_LIMIT));
`else
    assign w_starve_hit = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_grant) w_next_state = S_ACCESS;
            S_ACCESS: if (r_cnt == 4'd0) w_next_state = S_RESP;
            S_RESP:   w_next_state = w_grant ? S_ACCESS : S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_port_d  <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= 16'd0;
            r_i_rdata <= 16'd0;
            r_d_rdata <= 16'd0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_cnt    <= 4'(LATENCY - 1);
                r_port_d <= w_grant_d;
                r_wr     <= w_grant_d & d_wr;
                r_addr   <= w_grant_d ? d_addr : i_addr;
                r_wdata  <= w_grant_d ? d_wdata : 16'd0;
            end else if (r_state == S_ACCESS && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Capture at the end of the access cycle; write completions report zero data.
            if (w_access) begin
                if (r_port_d) begin
                    r_d_rdata <= r_wr ? 16'd0 : mem_data_out;
                end else begin
                    r_i_rdata <= mem_data_out;
                end
            end
        end
    end

    assign i_ready     = w_grant_i;
    assign d_ready     = w_grant_d;
    assign i_valid     = w_resp && !r_port_d;
    assign d_valid     = w_resp && r_port_d;
    assign align_err   = w_resp && r_addr[0];
    assign i_rdata     = r_i_rdata;
    assign d_rdata     = r_d_rdata;
    assign busy        = !rst && (r_state == S_ACCESS);
    assign mem_enable  = w_access;
    assign mem_wr      = w_access && r_wr;
    assign mem_addr    = {r_addr[ADDR_WIDTH-1:1], 1'b0};
    assign mem_data_in = r_wdata;
    assign o_dbg_state = r_state;

    assert property (@(posedge clk) disable iff (rst) mem_wr |-> mem_enable);
    assert property (@(posedge clk) disable iff (rst) !(i_ready && d_ready));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 16-bit, byte-addressed, single-cycle memory port between an instruction-fetch requester (I, read-only) and a data requester (D, read/write).
- Adds a programmable access latency so the pipeline can be exercised against multi-cycle memory timing.
- Sits between the fetch/memory pipeline stages and the memory macro.
- Exactly one access is in flight at a time.

Parameters:
- ADDR_WIDTH, 16: byte-address width of both requesters and the memory port.
- LATENCY, 4: cycles from accept to the memory access cycle. Legal range 1..15.
- STARVE_LIMIT, 3: consecutive D grants allowed while I is waiting. Used only with the optional feature.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- i_req, in, 1: fetch request. Held with i_addr until i_ready.
- i_addr, in, ADDR_WIDTH: fetch byte address.
- i_ready, out, 1: one-cycle accept pulse for I.
- i_valid, out, 1: one-cycle pulse; i_rdata is valid.
- i_rdata, out, 16: fetched word.
- d_req, in, 1: data request. Held with d_wr, d_addr and d_wdata until d_ready.
- d_wr, in, 1: 1 = write, 0 = read.
- d_addr, in, ADDR_WIDTH: data byte address.
- d_wdata, in, 16: write data.
- d_ready, out, 1: one-cycle accept pulse for D.
- d_valid, out, 1: one-cycle completion pulse (reads and writes).
- d_rdata, out, 16: read data. 0 on write completion.
- mem_addr, out, ADDR_WIDTH: memory address. Bit 0 always 0.
- mem_data_in, out, 16: memory write data.
- mem_enable, out, 1: memory enable.
- mem_wr, out, 1: memory write.
- mem_data_out, in, 16: combinational memory read data.
- busy, out, 1: an access is in flight.
- align_err, out, 1: one-cycle pulse with valid when the accepted address had bit 0 = 1.

Behaviour:
- Reset values: i_ready, d_ready, i_valid, d_valid, align_err, busy, mem_enable and mem_wr are all 0. rdata outputs are 0 and mem_addr/mem_data_in are 0. The FSM enters IDLE and the counter is cleared.
- While rst=1, mem_enable and mem_wr are gated to 0 combinationally, so the memory can load its image undisturbed.
- FSM states:
  - IDLE → ACCESS on grant.
  - ACCESS counts LATENCY cycles, then → RESP.
  - RESP → ACCESS if a request is granted in that cycle, else → IDLE.
- Grant rules:
  - Grants are issued only in IDLE or RESP.
  - A grant is the ready pulse in the same cycle as req, and is combinational from req and state.
  - On grant, the request fields are latched and the counter is loaded with LATENCY-1.
- Priority: fixed, D over I when both request.
- Accept timing (accept in cycle T):
  - busy=1 for cycles T+1..T+LATENCY.
  - The memory access cycle is T+LATENCY. In it: mem_enable=1, mem_wr=latched wr, mem_addr = {latched addr[ADDR_WIDTH-1:1], 1'b0}, mem_data_in = latched wdata.
  - Read data is captured from mem_data_out at the end of T+LATENCY.
  - The valid pulse and rdata appear in T+LATENCY+1 (RESP).
  - rdata holds its value until the next completion for that port.
- Outside the access cycle, mem_enable=0 and mem_wr=0, and the port never sees concurrent read/write. mem_wr is asserted in exactly one cycle per write.
- Throughput: back-to-back accesses complete every LATENCY+1 cycles, because RESP may accept a new request.
- Misaligned address: the access proceeds with bit 0 cleared. align_err pulses with the corresponding valid.
- Requester protocol: req/fields must stay stable until ready. Changing them before ready is a protocol error. A requester may drop req without ever being granted.
- Reset mid-access: the in-flight access is discarded, with no valid and no write if the reset edge precedes the access cycle.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit counter counts consecutive D grants made while i_req=1.
  - When the counter equals STARVE_LIMIT, the next contended grant goes to I.
  - The counter clears on any I grant, on any grant with i_req=0, and on reset.
- Undefined: pure fixed D priority, and no counter logic is present.

Test Plan:
1. LATENCY=4, I read at 0x0010 accepted in cycle T; memory word[8]=0xBEEF → mem_enable=1 only in T+4 with mem_addr=0x0010; i_valid=1 with i_rdata=0xBEEF in T+5.
2. D write 0x1234 to 0x0020, then D read of 0x0020 accepted in RESP of the write → mem_wr=1 in exactly one cycle; read returns d_rdata=0x1234 five cycles after its accept.
3. i_req and d_req both high in IDLE → d_ready=1 and i_ready=0; I is granted in the D access's RESP cycle.
4. D read of 0x0021 → mem_addr=0x0020; align_err=1 coincident with d_valid.
5. rst asserted in T+2 of a D write → mem_wr never 1, no d_valid; all outputs 0 in the cycle after the reset edge.
6. With MEM_ARB_STARVE_GUARD_EN, i_req and d_req held high → grant order D,D,D,I,D,D,D,I. Without the macro → D only.
